pedestrian_signal: RTL and testbench

Pedestrian crossing controller placed directly downstream of the vehicle traffic-light controller, on the same clock and `Enable` tick. It consumes the vehicle `Red`/`Yellow`/`Green` lamps and a push-button request, and drives the `Walk` and `DontWalk` lamps. A walk phase is granted only at the start of a vehicle red phase. It is followed by a timed clearance phase with a countdown. The block drops to a safe sticky-fault state on any illegal lamp combination.

---
 rtl/pedestrian_signal.sv | 129 ++++++++++++
 tb/tb_pedestrian_signal.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing controller slaved to the vehicle lamps; a walk is granted only on a red rise.
// Optional feature: define PED_FLASH_EN to flash DontWalk on each Enable tick during clearance.
module pedestrian_signal #(
  parameter int WALK_TICKS  = 16,
  parameter int CLEAR_TICKS = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Red,
  input  logic       Yellow,
  input  logic       Green,
  input  logic       Button,
  output logic       Walk,
  output logic       DontWalk,
  output logic       Waiting,
  output logic [4:0] Countdown,
  output logic       Fault,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WALK  = 3'd2,
    S_CLEAR = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [4:0] WALK_LOAD  = 5'(WALK_TICKS - 1);
  localparam logic [4:0] CLEAR_LOAD = 5'(CLEAR_TICKS - 1);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic       r_pending, w_pending_nxt;
  logic       r_red_q;
  logic       w_red_rise;
  logic       w_unsafe;
  logic       w_dw_clear;

  assign w_red_rise = Red & ~r_red_q;
  // Lamps must be one-hot, and red must stay lit for as long as pedestrians may be crossing.
  assign w_unsafe = ($countones({Red, Yellow, Green}) != 1) ||
                    (!Red && (r_state == S_WALK || r_state == S_CLEAR));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_pending <= 1'b0;
      r_red_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_red_q   <= Red;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    if (r_state != S_FAULT && w_unsafe) begin
      w_state_nxt   = S_FAULT;
      w_pending_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Button) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (w_red_rise) begin
            w_state_nxt = S_WALK;
            w_cnt_nxt   = WALK_LOAD;
          end
        end
        S_WALK: begin
          if (Enable) begin
            if (r_cnt == 5'd0) begin
              w_state_nxt = S_CLEAR;
              w_cnt_nxt   = CLEAR_LOAD;
            end else begin
              w_cnt_nxt = r_cnt - 5'd1;
            end
          end
        end
        S_CLEAR: begin
          if (Button) w_pending_nxt = 1'b1;
          if (Enable) begin
            if (r_cnt == 5'd0) begin
              // A press arriving on the final tick still counts as a new request.
              w_state_nxt   = (r_pending || Button) ? S_WAIT : S_IDLE;
              w_pending_nxt = 1'b0;
            end else begin
              w_cnt_nxt = r_cnt - 5'd1;
            end
          end
        end
        default: w_state_nxt = S_FAULT;
      endcase
    end
  end

`ifdef PED_FLASH_EN
  logic r_flash;

  // Held at 1 outside clearance so each clearance phase opens with DontWalk lit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_flash <= 1'b1;
    end else if (r_state != S_CLEAR) begin
      r_flash <= 1'b1;
    end else if (Enable) begin
      r_flash <= ~r_flash;
    end
  end

  assign w_dw_clear = r_flash;
`else
  assign w_dw_clear = 1'b1;
`endif

  assign Walk        = (r_state == S_WALK);
  assign DontWalk    = (r_state == S_CLEAR) ? w_dw_clear : (r_state != S_WALK);
  assign Waiting     = (r_state == S_WAIT) || (r_state == S_CLEAR && r_pending);
  assign Countdown   = (r_state == S_CLEAR) ? (r_cnt + 5'd1) : 5'd0;
  assign Fault       = (r_state == S_FAULT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pedestrian_signal.sv
// Scoreboard bench for pedestrian_signal with WALK_TICKS=4, CLEAR_TICKS=3.
// Expected output words are {Walk, DontWalk, Waiting, Countdown[4:0], Fault}.
module tb_pedestrian_signal;

  localparam int W = 9;

`ifdef PED_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  localparam logic [W-1:0] E_IDLE  = 9'b0_1_0_00000_0;
  localparam logic [W-1:0] E_WAIT  = 9'b0_1_1_00000_0;
  localparam logic [W-1:0] E_WALK  = 9'b1_0_0_00000_0;
  localparam logic [W-1:0] E_FAULT = 9'b0_1_0_00000_1;

  logic       Clock = 1'b0;
  logic       Reset, Enable, Red, Yellow, Green, Button;
  logic       Walk, DontWalk, Waiting, Fault;
  logic [4:0] Countdown;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 Clock = ~Clock;

  pedestrian_signal #(.WALK_TICKS(4), .CLEAR_TICKS(3)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Red        (Red),
    .Yellow     (Yellow),
    .Green      (Green),
    .Button     (Button),
    .Walk       (Walk),
    .DontWalk   (DontWalk),
    .Waiting    (Waiting),
    .Countdown  (Countdown),
    .Fault      (Fault),
    .o_dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] e_clear(input int cd, input bit dw, input bit waiting);
    return {1'b0, dw, waiting, 5'(cd), 1'b0};
  endfunction

  function automatic logic [W-1:0] observed();
    return {Walk, DontWalk, Waiting, Countdown, Fault};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
  endtask

  // driver: apply inputs, expect the outputs after the next rising edge
  task automatic cyc(input logic [2:0] lamps, input logic btn, input logic en,
                     input logic [W-1:0] exp, input string tag);
    {Red, Yellow, Green} = lamps;
    Button = btn;
    Enable = en;
    exp_q.push_back(exp);
    @(posedge Clock);
    #2;
    check(tag, observed(), exp_q.pop_front());
  endtask

  task automatic expect_now(input string tag, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    check(tag, observed(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    Button = 1'b0;
    Enable = 1'b1;
    {Red, Yellow, Green} = L_G;
    #3;
    expect_now("reset", E_IDLE);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #2;
  endtask

  // Remainder of a walk once the first WALK cycle has been observed, red held.
  task automatic walk_tail(input string tag);
    for (int i = 0; i < 3; i++) cyc(L_R, 1'b0, 1'b1, E_WALK, {tag, "_walk"});
    cyc(L_R, 1'b0, 1'b1, e_clear(3, 1'b1, 1'b0), {tag, "_clr3"});
    cyc(L_R, 1'b0, 1'b1, e_clear(2, FLASH ? 1'b0 : 1'b1, 1'b0), {tag, "_clr2"});
    cyc(L_R, 1'b0, 1'b1, e_clear(1, 1'b1, 1'b0), {tag, "_clr1"});
    cyc(L_R, 1'b0, 1'b1, E_IDLE, {tag, "_idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Enable = 1'b1; Button = 1'b0;
    {Red, Yellow, Green} = L_G;
    #2;
    do_reset();
    cyc(L_G, 1'b0, 1'b1, E_IDLE, "idle_hold");

    // button during green, then red rises
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "btn_wait");
    cyc(L_G, 1'b0, 1'b1, E_WAIT, "wait_hold");
    cyc(L_Y, 1'b0, 1'b1, E_WAIT, "wait_yellow");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "rise_walk");
    walk_tail("basic");
    cyc(L_R, 1'b0, 1'b1, E_IDLE, "idle_after");

    // button pressed while red is already lit
    cyc(L_R, 1'b1, 1'b1, E_WAIT, "midred_btn");
    for (int i = 0; i < 3; i++) cyc(L_R, 1'b0, 1'b1, E_WAIT, "midred_nowalk");
    cyc(L_G, 1'b0, 1'b1, E_WAIT, "midred_green");
    cyc(L_Y, 1'b0, 1'b1, E_WAIT, "midred_yellow");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "next_rise_walk");
    walk_tail("midred");

    // Enable low during WALK and CLEAR, plus a pending press in CLEAR
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "en_btn");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "en_rise");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "en_tick1");
    for (int i = 0; i < 5; i++) cyc(L_R, 1'b0, 1'b0, E_WALK, "en_low_walk");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "en_tick2");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "en_tick3");
    cyc(L_R, 1'b0, 1'b1, e_clear(3, 1'b1, 1'b0), "en_tick4_clear");
    cyc(L_R, 1'b0, 1'b0, e_clear(3, 1'b1, 1'b0), "clr_frozen");
    cyc(L_R, 1'b1, 1'b1, e_clear(2, FLASH ? 1'b0 : 1'b1, 1'b1), "clr_pend");
    cyc(L_R, 1'b0, 1'b1, e_clear(1, 1'b1, 1'b1), "clr_pend_hold");
    cyc(L_R, 1'b0, 1'b1, E_WAIT, "pend_wait");
    cyc(L_G, 1'b0, 1'b1, E_WAIT, "pend_green");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "pend_walk");
    walk_tail("pend");

    // red dropped during WALK
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "f1_btn");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "f1_walk");
    cyc(L_G, 1'b0, 1'b1, E_FAULT, "red_drop_fault");
    cyc(L_R, 1'b1, 1'b1, E_FAULT, "fault_sticky_btn");
    cyc(L_G, 1'b0, 1'b0, E_FAULT, "fault_sticky");
    do_reset();

    // red and green both lit during WALK
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "f2_btn");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "f2_walk");
    cyc(L_R | L_G, 1'b0, 1'b1, E_FAULT, "red_green_fault");
    cyc(L_R, 1'b0, 1'b1, E_FAULT, "f2_sticky");
    do_reset();

    // no lamp lit while idle
    cyc(3'b000, 1'b0, 1'b1, E_FAULT, "no_lamp_fault");
    do_reset();

    // asynchronous reset in the middle of CLEAR
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "r_btn");
    cyc(L_R, 1'b0, 1'b1, E_WALK, "r_walk");
    for (int i = 0; i < 3; i++) cyc(L_R, 1'b0, 1'b1, E_WALK, "r_walk_run");
    cyc(L_R, 1'b0, 1'b1, e_clear(3, 1'b1, 1'b0), "r_clear");
    #1;
    Reset = 1'b1;
    #1;
    expect_now("reset_midclear", E_IDLE);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #2;
    cyc(L_G, 1'b0, 1'b1, E_IDLE, "post_reset_idle");
    cyc(L_G, 1'b1, 1'b1, E_WAIT, "post_reset_btn");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
